// File: rtl/mem_if_pkg.sv
// Shared widths and FSM state encoding for the memory-side line responder.
package mem_if_pkg;

  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_resp_array.sv
// Word-addressed backing store: one 32-bit write port and one combinational 4-word line read port.
module mem_resp_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [LINE_W-1:0] o_rline
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic              w_unused_ridx;

  // Word write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  // The line base always has its two low index bits cleared.
  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_line
    assign o_rline[WORD_W*k +: WORD_W] = r_mem[{i_ridx[IDX_W-1:2], 2'(k)}];
  end

  assign w_unused_ridx = ^i_ridx[1:0];

endmodule

// File: rtl/mem_line_responder.sv
// Single-outstanding memory responder: fixed-latency line reads and word writes.
// Optional feature macro: MEM_RESP_ERR_EN (flags and suppresses out-of-range accesses).
module mem_line_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_write,
  output logic [LINE_W-1:0] resp_data,
`ifdef MEM_RESP_ERR_EN
  output logic              resp_err,
`endif
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_write;
  logic               r_err;
  logic [IDX_W-1:0]   r_idx;
  logic [LINE_W-1:0]  r_data;

  logic               w_accept;
  logic               w_req_err;
  logic               w_we;
  logic [IDX_W-1:0]   w_req_idx;
  logic [IDX_W-1:0]   w_ridx;
  logic [LINE_W-1:0]  w_rline;
  logic               w_cur_write;
  logic               w_cur_err;
  logic               w_load_resp;
  logic               w_unused_addr;

  assign w_accept  = req_valid & (r_state == IDLE);
  assign w_req_idx = req_addr[IDX_W+1:2];

`ifdef MEM_RESP_ERR_EN
  assign w_req_err     = ((req_addr >> (IDX_W + 2)) != {ADDR_W{1'b0}});
  assign w_unused_addr = ^req_addr[1:0];
`else
  assign w_req_err     = 1'b0;
  assign w_unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
`endif

  assign w_we = w_accept & req_write & ~w_req_err;

  // With LATENCY=1 the line is captured on the acceptance edge, so read straight from the request.
  assign w_ridx      = (r_state == IDLE) ? w_req_idx : r_idx;
  assign w_cur_write = (r_state == IDLE) ? req_write : r_write;
  assign w_cur_err   = (r_state == IDLE) ? w_req_err : r_err;
  assign w_load_resp = (w_state_nxt == RESP) & (r_state != RESP);

  mem_resp_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (w_req_idx),
    .i_wdata (req_wdata),
    .i_ridx  (w_ridx),
    .o_rline (w_rline)
  );

  // Next-state and latency counter; the counter spans the LATENCY-1 WAIT cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, counter and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_err   <= w_req_err;
        r_idx   <= w_req_idx;
      end
    end
  end

  // Response line, held until the next response is formed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {LINE_W{1'b0}};
    end else if (w_load_resp) begin
      r_data <= (w_cur_write | w_cur_err) ? {LINE_W{1'b0}} : w_rline;
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_write = r_write;
  assign resp_data  = r_data;
`ifdef MEM_RESP_ERR_EN
  assign resp_err   = r_err;
`endif

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
Memory-side responder for the data cache's line-fill and write-through traffic. It accepts one request at a time over a valid/ready handshake and owns a word-addressed backing array. Reads return a full 128-bit line after a fixed, programmable latency. Writes commit a single 32-bit word and are acknowledged after the same latency. It sits between the cache miss/refill logic and the backing store, and replaces the zero-latency combinational data memory path.

Parameters:
LATENCY, 4, cycles from request acceptance to resp_valid; legal range 1..15
DEPTH, 1024, backing array size in 32-bit words; power of two, minimum 4
ADDR_W, 32, width of the request byte address

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = word write, 0 = line read
req_addr  input  ADDR_W  byte address
req_wdata  input  32  write data (used when req_write=1)
resp_valid  output  1  single-cycle response strobe
resp_write  output  1  echo of the accepted req_write
resp_data  output  128  read line; word k in bits [32k+31:32k]; zero for write responses
busy  output  1  high in WAIT and RESP

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n); no synchronous reset path.
- Reset values: req_ready=1, resp_valid=0, resp_write=0, resp_data=0, busy=0, state=IDLE, counter=0. The backing array is never cleared by reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata, load counter=LATENCY-1, go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle; at counter==0 go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency: a request accepted at edge N produces resp_valid high in cycle N+LATENCY. Back-to-back throughput is one request per LATENCY+1 cycles.
- Indexing: word index = req_addr[2+log2(DEPTH)-1:2]. For reads, the line base = index with bits [1:0] cleared. resp_data holds words base+0..base+3 regardless of the low offset. req_addr[1:0] is ignored.
- Write commit: the word is written to the array on the acceptance edge. A read accepted afterwards returns the new value.
- resp_data is registered. It is loaded on the WAIT->RESP (or IDLE->RESP) edge and held until the next response; it is not cleared after RESP.
- req_* changes while busy are ignored. There is no queueing; the requester holds req_valid until it sees req_ready.
- Out-of-range address (any bit above the index field set): the address wraps, and the upper bits are ignored.
- Reset mid-operation: the transaction is aborted and no resp_valid is issued. A write accepted before reset stays committed.
- Simultaneous req_valid in RESP: not accepted, because req_ready=0. It is accepted on the following IDLE cycle.

Optional Feature:
MEM_RESP_ERR_EN
- Defined: adds output resp_err (1 bit, reset 0), valid with resp_valid. If any req_addr bit above the index field is set:
  - resp_err=1;
  - a write is dropped and leaves the array unchanged;
  - a read returns resp_data=0.
  - Latency is unchanged.
- Undefined: no resp_err port, and out-of-range addresses wrap as described in Behaviour.

Decomposition:
- Package mem_if_pkg holds:
  - localparams WORD_W=32, LINE_W=128, WORDS_PER_LINE=4;
  - the state enum (IDLE, WAIT, RESP) as 2-bit localparams.
- One sub-module, mem_resp_array: DEPTH x 32 storage with one word write port and a 4-word line read port. The FSM and latency counter stay in mem_line_responder.

Test Plan:
1. Reset: rst_n=0 for 3 cycles then 1 -> req_ready=1, resp_valid=0, busy=0, resp_data=0.
2. Write then read (LATENCY=4): write addr 0x0000_0014, data 0xDEADBEEF, accepted at cycle 10 -> resp_valid at cycle 14 with resp_write=1. Then read addr 0x0000_0010 -> resp_data[63:32]=0xDEADBEEF, resp_valid exactly LATENCY cycles after acceptance.
3. Backpressure: hold req_valid=1 with a read to 0x20 while busy -> req_ready=0 through WAIT/RESP. The second request is accepted on the IDLE cycle following resp_valid (spacing 5 cycles).
4. Offset ignore: read 0x0000_001C vs 0x0000_0010 -> identical 128-bit resp_data.
5. Reset mid-op: assert rst_n=0 two cycles after accepting a read -> no resp_valid, req_ready=1 immediately. A prior write to 0x40 is still readable after release.
6. Out-of-range, DEPTH=1024, addr 0x0000_1010: without macro -> data of 0x0000_0010. With MEM_RESP_ERR_EN -> resp_err=1, resp_data=0, and a write to that address leaves 0x10 unchanged.
